// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if
//   Groups the reservation-station dispatch bus and the ALU side of the CDB.
//   master : reservation station / CDB arbiter side (drives dispatch + grant)
//   slave  : alu_exec_unit side (drives stall + broadcast)
//   Signals:
//     ALU_enable, op_to_ALU, Vj_to_ALU, Vk_to_ALU, imm_to_ALU,
//     rdTag_to_ALU, pc_to_ALU          dispatch micro-op
//     alu_stall                        hold dispatch
//     cdb_grant                        CDB grant for the ALU source
//     B_ALU_valid/result/rdTag/jump/target   CDB broadcast
`ifndef ROBRange
`define ROBRange 3:0
`endif

interface alu_exec_unit_if;
    logic                ALU_enable;
    logic [5:0]          op_to_ALU;
    logic [31:0]         Vj_to_ALU;
    logic [31:0]         Vk_to_ALU;
    logic [31:0]         imm_to_ALU;
    logic [`ROBRange]    rdTag_to_ALU;
    logic [31:0]         pc_to_ALU;
    logic                alu_stall;
    logic                cdb_grant;
    logic                B_ALU_valid;
    logic [31:0]         B_ALU_result;
    logic [`ROBRange]    B_ALU_rdTag;
    logic                B_ALU_jump;
    logic [31:0]         B_ALU_target;

    modport master (
        output ALU_enable, op_to_ALU, Vj_to_ALU, Vk_to_ALU, imm_to_ALU,
               rdTag_to_ALU, pc_to_ALU, cdb_grant,
        input  alu_stall, B_ALU_valid, B_ALU_result, B_ALU_rdTag,
               B_ALU_jump, B_ALU_target
    );

    modport slave (
        input  ALU_enable, op_to_ALU, Vj_to_ALU, Vk_to_ALU, imm_to_ALU,
               rdTag_to_ALU, pc_to_ALU, cdb_grant,
        output alu_stall, B_ALU_valid, B_ALU_result, B_ALU_rdTag,
               B_ALU_jump, B_ALU_target
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execution endpoint of the RS dispatch bus. One ALU/branch micro-op per
//   cycle is captured in stage S1, computed combinationally, then pushed
//   into an in-order result queue whose head drives the ALU side of the CDB.
//   Ports:
//     clk          clock
//     rst          asynchronous active-low reset
//     rdy          global ready; low freezes all state
//     rollback     synchronous flush of S1 and the result queue
//     bus          alu_exec_unit_if.slave (dispatch, stall, grant, CDB)
//     alu_overflow sticky flag: an op was dropped because the queue was full
//   Build option:
//     ALU_CDB_BYPASS_EN  when defined, an S1 result is broadcast directly
//                        (not enqueued) if the queue is empty and the CDB
//                        is granted, giving 1-edge latency.
`ifndef ROBRange
`define ROBRange 3:0
`endif

module alu_exec_unit #(
    parameter int QDEPTH = 4,
    parameter int QW     = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
    input  logic           rollback,
    alu_exec_unit_if.slave bus,
    output logic           alu_overflow
);

    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_LUI   = 6'd1;
    localparam logic [5:0] OP_AUIPC = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_JALR  = 6'd4;
    localparam logic [5:0] OP_BEQ   = 6'd5;
    localparam logic [5:0] OP_BNE   = 6'd6;
    localparam logic [5:0] OP_BLT   = 6'd7;
    localparam logic [5:0] OP_BGE   = 6'd8;
    localparam logic [5:0] OP_BLTU  = 6'd9;
    localparam logic [5:0] OP_BGEU  = 6'd10;
    localparam logic [5:0] OP_ADDI  = 6'd11;
    localparam logic [5:0] OP_SLTI  = 6'd12;
    localparam logic [5:0] OP_SLTIU = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_ORI   = 6'd15;
    localparam logic [5:0] OP_ANDI  = 6'd16;
    localparam logic [5:0] OP_SLLI  = 6'd17;
    localparam logic [5:0] OP_SRLI  = 6'd18;
    localparam logic [5:0] OP_SRAI  = 6'd19;
    localparam logic [5:0] OP_ADD   = 6'd20;
    localparam logic [5:0] OP_SUB   = 6'd21;
    localparam logic [5:0] OP_SLL   = 6'd22;
    localparam logic [5:0] OP_SLT   = 6'd23;
    localparam logic [5:0] OP_SLTU  = 6'd24;
    localparam logic [5:0] OP_XOR   = 6'd25;
    localparam logic [5:0] OP_SRL   = 6'd26;
    localparam logic [5:0] OP_SRA   = 6'd27;
    localparam logic [5:0] OP_OR    = 6'd28;
    localparam logic [5:0] OP_AND   = 6'd29;

    localparam logic [QW:0]   FULL_CNT  = (QW+1)'(QDEPTH);
    localparam logic [QW+1:0] STALL_LVL = (QW+2)'(QDEPTH - 1);

    typedef struct packed {
        logic [31:0]      result;
        logic [`ROBRange] tag;
        logic             jump;
        logic [31:0]      target;
    } entry_t;

    // S1 stage
    logic             s1_valid_q, s1_valid_d;
    logic [5:0]       s1_op_q,    s1_op_d;
    logic [31:0]      s1_vj_q,    s1_vj_d;
    logic [31:0]      s1_vk_q,    s1_vk_d;
    logic [31:0]      s1_imm_q,   s1_imm_d;
    logic [`ROBRange] s1_tag_q,   s1_tag_d;
    logic [31:0]      s1_pc_q,    s1_pc_d;

    // result queue
    entry_t           q_mem_q [QDEPTH];
    entry_t           q_mem_d [QDEPTH];
    logic [QW-1:0]    head_q, head_d;
    logic [QW-1:0]    tail_q, tail_d;
    logic [QW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;

    // compute
    logic [31:0]      res_c;
    logic             jump_c;
    logic [31:0]      target_c;
    logic [4:0]       shamt_r;
    logic [4:0]       shamt_i;
    entry_t           s1_entry;

    // control
    logic             q_empty;
    logic             q_full;
    logic             bypass;
    logic             pop;
    logic             push_req;
    logic             push_drop;
    logic             disp_drop;
    logic             push;
    logic [QW+1:0]    occupancy;

    // ------------------------------------------------------------------
    // Combinational execute of the S1 micro-op
    // ------------------------------------------------------------------
    always_comb begin
        shamt_r  = s1_vk_q[4:0];
        shamt_i  = s1_imm_q[4:0];
        res_c    = 32'd0;
        jump_c   = 1'b0;
        target_c = s1_pc_q + 32'd4;
        case (s1_op_q)
            OP_LUI:   res_c = s1_imm_q;
            OP_AUIPC: res_c = s1_pc_q + s1_imm_q;
            OP_JAL: begin
                res_c    = s1_pc_q + 32'd4;
                jump_c   = 1'b1;
                target_c = s1_pc_q + s1_imm_q;
            end
            OP_JALR: begin
                res_c    = s1_pc_q + 32'd4;
                jump_c   = 1'b1;
                target_c = (s1_vj_q + s1_imm_q) & 32'hFFFF_FFFE;
            end
            OP_BEQ: begin
                jump_c   = (s1_vj_q == s1_vk_q);
                target_c = s1_pc_q + s1_imm_q;
            end
            OP_BNE: begin
                jump_c   = (s1_vj_q != s1_vk_q);
                target_c = s1_pc_q + s1_imm_q;
            end
            OP_BLT: begin
                jump_c   = ($signed(s1_vj_q) < $signed(s1_vk_q));
                target_c = s1_pc_q + s1_imm_q;
            end
            OP_BGE: begin
                jump_c   = ($signed(s1_vj_q) >= $signed(s1_vk_q));
                target_c = s1_pc_q + s1_imm_q;
            end
            OP_BLTU: begin
                jump_c   = (s1_vj_q < s1_vk_q);
                target_c = s1_pc_q + s1_imm_q;
            end
            OP_BGEU: begin
                jump_c   = (s1_vj_q >= s1_vk_q);
                target_c = s1_pc_q + s1_imm_q;
            end
            OP_ADDI:  res_c = s1_vj_q + s1_imm_q;
            OP_SLTI:  res_c = {31'd0, $signed(s1_vj_q) < $signed(s1_imm_q)};
            OP_SLTIU: res_c = {31'd0, s1_vj_q < s1_imm_q};
            OP_XORI:  res_c = s1_vj_q ^ s1_imm_q;
            OP_ORI:   res_c = s1_vj_q | s1_imm_q;
            OP_ANDI:  res_c = s1_vj_q & s1_imm_q;
            OP_SLLI:  res_c = s1_vj_q << shamt_i;
            OP_SRLI:  res_c = s1_vj_q >> shamt_i;
            OP_SRAI:  res_c = $unsigned($signed(s1_vj_q) >>> shamt_i);
            OP_ADD:   res_c = s1_vj_q + s1_vk_q;
            OP_SUB:   res_c = s1_vj_q - s1_vk_q;
            OP_SLL:   res_c = s1_vj_q << shamt_r;
            OP_SLT:   res_c = {31'd0, $signed(s1_vj_q) < $signed(s1_vk_q)};
            OP_SLTU:  res_c = {31'd0, s1_vj_q < s1_vk_q};
            OP_XOR:   res_c = s1_vj_q ^ s1_vk_q;
            OP_SRL:   res_c = s1_vj_q >> shamt_r;
            OP_SRA:   res_c = $unsigned($signed(s1_vj_q) >>> shamt_r);
            OP_OR:    res_c = s1_vj_q | s1_vk_q;
            OP_AND:   res_c = s1_vj_q & s1_vk_q;
            OP_NOP:   res_c = 32'd0;
            default:  res_c = 32'd0;
        endcase

        s1_entry.result = res_c;
        s1_entry.tag    = s1_tag_q;
        s1_entry.jump   = jump_c;
        s1_entry.target = target_c;
    end

    // ------------------------------------------------------------------
    // Queue control
    // ------------------------------------------------------------------
    always_comb begin
        q_empty = (count_q == '0);
        q_full  = (count_q == FULL_CNT);
`ifdef ALU_CDB_BYPASS_EN
        bypass  = rdy && s1_valid_q && q_empty && bus.cdb_grant;
`else
        bypass  = 1'b0;
`endif
        pop       = rdy && !q_empty && bus.cdb_grant;
        push_req  = s1_valid_q && !bypass;
        // A full queue only has room this cycle if the head is leaving.
        push_drop = push_req && q_full && !pop;
        disp_drop = bus.ALU_enable && q_full && !pop;
        push      = push_req && !push_drop;
        occupancy = (QW+2)'(count_q) + (QW+2)'(s1_valid_q);
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_vj_d    = s1_vj_q;
        s1_vk_d    = s1_vk_q;
        s1_imm_d   = s1_imm_q;
        s1_tag_d   = s1_tag_q;
        s1_pc_d    = s1_pc_q;
        q_mem_d    = q_mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        ovf_d      = ovf_q;

        if (rdy) begin
            if (rollback) begin
                s1_valid_d = 1'b0;
                head_d     = '0;
                tail_d     = '0;
                count_d    = '0;
            end else begin
                s1_valid_d = bus.ALU_enable && !disp_drop;
                if (bus.ALU_enable) begin
                    s1_op_d  = bus.op_to_ALU;
                    s1_vj_d  = bus.Vj_to_ALU;
                    s1_vk_d  = bus.Vk_to_ALU;
                    s1_imm_d = bus.imm_to_ALU;
                    s1_tag_d = bus.rdTag_to_ALU;
                    s1_pc_d  = bus.pc_to_ALU;
                end
                if (push) begin
                    q_mem_d[tail_q] = s1_entry;
                    tail_d          = tail_q + QW'(1);
                end
                if (pop) begin
                    head_d = head_q + QW'(1);
                end
                if (push && !pop) begin
                    count_d = count_q + (QW+1)'(1);
                end else if (pop && !push) begin
                    count_d = count_q - (QW+1)'(1);
                end
                if (push_drop || disp_drop) begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_vj_q    <= '0;
            s1_vk_q    <= '0;
            s1_imm_q   <= '0;
            s1_tag_q   <= '0;
            s1_pc_q    <= '0;
            q_mem_q    <= '{default: '0};
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_vj_q    <= s1_vj_d;
            s1_vk_q    <= s1_vk_d;
            s1_imm_q   <= s1_imm_d;
            s1_tag_q   <= s1_tag_d;
            s1_pc_q    <= s1_pc_d;
            q_mem_q    <= q_mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: broadcast data is forced to zero when nothing is valid so
    // stale queue slots never leak onto the CDB.
    // ------------------------------------------------------------------
    entry_t out_entry;

    always_comb begin
        out_entry = '0;
        if (bypass) begin
            out_entry = s1_entry;
        end else if (!q_empty) begin
            out_entry = q_mem_q[head_q];
        end
    end

    assign bus.B_ALU_valid  = !q_empty || bypass;
    assign bus.B_ALU_result = out_entry.result;
    assign bus.B_ALU_rdTag  = out_entry.tag;
    assign bus.B_ALU_jump   = out_entry.jump;
    assign bus.B_ALU_target = out_entry.target;
    // Combinational so the op already sitting in S1 is always accounted for.
    assign bus.alu_stall    = (occupancy >= STALL_LVL);
    assign alu_overflow     = ovf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
`ifndef ROBRange
`define ROBRange 3:0
`endif

module tb_alu_exec_unit;

    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_LUI   = 6'd1;
    localparam logic [5:0] OP_AUIPC = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_JALR  = 6'd4;
    localparam logic [5:0] OP_BEQ   = 6'd5;
    localparam logic [5:0] OP_BNE   = 6'd6;
    localparam logic [5:0] OP_BLT   = 6'd7;
    localparam logic [5:0] OP_BGE   = 6'd8;
    localparam logic [5:0] OP_BLTU  = 6'd9;
    localparam logic [5:0] OP_BGEU  = 6'd10;
    localparam logic [5:0] OP_ADDI  = 6'd11;
    localparam logic [5:0] OP_SLTIU = 6'd13;
    localparam logic [5:0] OP_ORI   = 6'd15;
    localparam logic [5:0] OP_SRAI  = 6'd19;
    localparam logic [5:0] OP_ADD   = 6'd20;
    localparam logic [5:0] OP_SUB   = 6'd21;
    localparam logic [5:0] OP_SLL   = 6'd22;
    localparam logic [5:0] OP_SLT   = 6'd23;
    localparam logic [5:0] OP_SLTU  = 6'd24;
    localparam logic [5:0] OP_XOR   = 6'd25;
    localparam logic [5:0] OP_SRL   = 6'd26;
    localparam logic [5:0] OP_SRA   = 6'd27;
    localparam logic [5:0] OP_AND   = 6'd29;

`ifdef ALU_CDB_BYPASS_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 2;
`endif

    typedef struct packed {
        logic [5:0]       op;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic [31:0]      imm;
        logic [31:0]      pc;
        logic [`ROBRange] tag;
        logic [31:0]      res;
        logic             jmp;
        logic [31:0]      tgt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic rollback;
    logic alu_overflow;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [24];

    alu_exec_unit_if bus();

    alu_exec_unit #(.QDEPTH(4), .QW(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .rollback     (rollback),
        .bus          (bus.slave),
        .alu_overflow (alu_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                                input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag,
                                input logic [31:0] res, input logic jmp, input logic [31:0] tgt);
        vec_t v;
        v.op = op; v.vj = vj; v.vk = vk; v.imm = imm; v.pc = pc; v.tag = tag;
        v.res = res; v.jmp = jmp; v.tgt = tgt;
        return v;
    endfunction

    task automatic drive(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
        bus.ALU_enable   = 1'b1;
        bus.op_to_ALU    = op;
        bus.Vj_to_ALU    = vj;
        bus.Vk_to_ALU    = vk;
        bus.imm_to_ALU   = imm;
        bus.pc_to_ALU    = pc;
        bus.rdTag_to_ALU = tag;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Dispatch one op with grant=1 and measure edges until broadcast.
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        drive(v.op, v.vj, v.vk, v.imm, v.pc, v.tag);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.ALU_enable = 1'b0;
        while (!bus.B_ALU_valid && lat < 10) begin
            cyc();
            lat++;
        end
        chk($sformatf("v%0d valid", idx), {31'd0, bus.B_ALU_valid}, 32'd1);
        chk($sformatf("v%0d latency", idx), lat, EXP_LAT);
        chk($sformatf("v%0d result", idx), bus.B_ALU_result, v.res);
        chk($sformatf("v%0d tag", idx), {28'd0, bus.B_ALU_rdTag}, {28'd0, v.tag});
        chk($sformatf("v%0d jump", idx), {31'd0, bus.B_ALU_jump}, {31'd0, v.jmp});
        chk($sformatf("v%0d target", idx), bus.B_ALU_target, v.tgt);
    endtask

    task automatic chk_zero_outputs(input string pfx);
        chk({pfx, " valid"},    {31'd0, bus.B_ALU_valid}, 32'd0);
        chk({pfx, " result"},   bus.B_ALU_result, 32'd0);
        chk({pfx, " tag"},      {28'd0, bus.B_ALU_rdTag}, 32'd0);
        chk({pfx, " jump"},     {31'd0, bus.B_ALU_jump}, 32'd0);
        chk({pfx, " target"},   bus.B_ALU_target, 32'd0);
        chk({pfx, " stall"},    {31'd0, bus.alu_stall}, 32'd0);
        chk({pfx, " overflow"}, {31'd0, alu_overflow}, 32'd0);
    endtask

    initial begin
        bit saw;
        vecs[0]  = mk(OP_ADD,   32'd5,          32'd7,          32'd0,          32'h0,          4'd3,  32'd12,         1'b0, 32'h4);
        vecs[1]  = mk(OP_SUB,   32'd10,         32'd3,          32'd0,          32'h8,          4'd4,  32'd7,          1'b0, 32'hC);
        vecs[2]  = mk(OP_SUB,   32'd3,          32'd10,         32'd0,          32'h10,         4'd5,  32'hFFFF_FFF9,  1'b0, 32'h14);
        vecs[3]  = mk(OP_AND,   32'h0000_F0F0,  32'h0000_FF00,  32'd0,          32'h20,         4'd6,  32'h0000_F000,  1'b0, 32'h24);
        vecs[4]  = mk(OP_ORI,   32'h0000_0F00,  32'hDEAD_BEEF,  32'h0000_00FF,  32'h24,         4'd7,  32'h0000_0FFF,  1'b0, 32'h28);
        vecs[5]  = mk(OP_XOR,   32'hFFFF_0000,  32'h0FF0_0FF0,  32'd0,          32'h28,         4'd8,  32'hF00F_0FF0,  1'b0, 32'h2C);
        vecs[6]  = mk(OP_SLT,   32'hFFFF_FFFF,  32'd1,          32'd0,          32'h30,         4'd9,  32'd1,          1'b0, 32'h34);
        vecs[7]  = mk(OP_SLTU,  32'hFFFF_FFFF,  32'd1,          32'd0,          32'h34,         4'd10, 32'd0,          1'b0, 32'h38);
        vecs[8]  = mk(OP_SLTIU, 32'd1,          32'd0,          32'hFFFF_FFFF,  32'h38,         4'd11, 32'd1,          1'b0, 32'h3C);
        vecs[9]  = mk(OP_SLL,   32'd1,          32'h0000_0023,  32'd0,          32'h3C,         4'd12, 32'd8,          1'b0, 32'h40);
        vecs[10] = mk(OP_SRA,   32'h8000_0000,  32'd4,          32'd0,          32'h40,         4'd13, 32'hF800_0000,  1'b0, 32'h44);
        vecs[11] = mk(OP_SRL,   32'h8000_0000,  32'd4,          32'd0,          32'h44,         4'd14, 32'h0800_0000,  1'b0, 32'h48);
        vecs[12] = mk(OP_SRAI,  32'h8000_0000,  32'd0,          32'd31,         32'h48,         4'd15, 32'hFFFF_FFFF,  1'b0, 32'h4C);
        vecs[13] = mk(OP_LUI,   32'd0,          32'd0,          32'h1234_5000,  32'h10,         4'd1,  32'h1234_5000,  1'b0, 32'h14);
        vecs[14] = mk(OP_AUIPC, 32'd0,          32'd0,          32'h0000_2000,  32'h1000,       4'd2,  32'h0000_3000,  1'b0, 32'h1004);
        vecs[15] = mk(OP_JAL,   32'd0,          32'd0,          32'h10,         32'h200,        4'd3,  32'h204,        1'b1, 32'h210);
        vecs[16] = mk(OP_JALR,  32'h1003,       32'd0,          32'd4,          32'h40,         4'd4,  32'h44,         1'b1, 32'h1006);
        vecs[17] = mk(OP_BLT,   32'hFFFF_FFFF,  32'd1,          32'h20,         32'h100,        4'd5,  32'd0,          1'b1, 32'h120);
        vecs[18] = mk(OP_BLTU,  32'hFFFF_FFFF,  32'd1,          32'h20,         32'h100,        4'd6,  32'd0,          1'b0, 32'h120);
        vecs[19] = mk(OP_BEQ,   32'd5,          32'd5,          32'hFFFF_FFF0,  32'h300,        4'd7,  32'd0,          1'b1, 32'h2F0);
        vecs[20] = mk(OP_BNE,   32'd5,          32'd5,          32'hFFFF_FFF0,  32'h300,        4'd8,  32'd0,          1'b0, 32'h2F0);
        vecs[21] = mk(OP_BGE,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd8,          32'h0,          4'd9,  32'd0,          1'b1, 32'h8);
        vecs[22] = mk(OP_BGEU,  32'd1,          32'hFFFF_FFFF,  32'd8,          32'h10,         4'd10, 32'd0,          1'b0, 32'h18);
        vecs[23] = mk(OP_ADDI,  32'hFFFF_FFFF,  32'd0,          32'd1,          32'hFFFF_FFFC,  4'd11, 32'd0,          1'b0, 32'h0);

        rst = 1'b0;
        rdy = 1'b1;
        rollback = 1'b0;
        bus.ALU_enable = 1'b0;
        bus.op_to_ALU = OP_NOP;
        bus.Vj_to_ALU = '0;
        bus.Vk_to_ALU = '0;
        bus.imm_to_ALU = '0;
        bus.pc_to_ALU = '0;
        bus.rdTag_to_ALU = '0;
        bus.cdb_grant = 1'b0;

        #12;
        chk_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Compute table
        bus.cdb_grant = 1'b1;
        for (int i = 0; i < 24; i++) begin
            run_vec(vecs[i], i);
        end
        cyc();
        chk("drained valid", {31'd0, bus.B_ALU_valid}, 32'd0);

        // Fill with grant low: stall threshold and overflow on the 5th op
        bus.cdb_grant = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            drive(OP_ADD, k * 100, k, 32'd0, 32'h0, 4'(k));
            cyc();
            chk($sformatf("fill%0d stall", k), {31'd0, bus.alu_stall}, (k >= 3) ? 32'd1 : 32'd0);
            chk($sformatf("fill%0d overflow", k), {31'd0, alu_overflow}, 32'd0);
        end
        bus.ALU_enable = 1'b0;
        cyc();
        chk("full overflow", {31'd0, alu_overflow}, 32'd1);
        chk("full stall", {31'd0, bus.alu_stall}, 32'd1);
        bus.cdb_grant = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("drain%0d valid", k), {31'd0, bus.B_ALU_valid}, 32'd1);
            chk($sformatf("drain%0d tag", k), {28'd0, bus.B_ALU_rdTag}, k);
            chk($sformatf("drain%0d result", k), bus.B_ALU_result, k * 101);
            cyc();
        end
        chk("drain empty", {31'd0, bus.B_ALU_valid}, 32'd0);
        chk("drain stall", {31'd0, bus.alu_stall}, 32'd0);
        chk("overflow sticky", {31'd0, alu_overflow}, 32'd1);

        // Rollback with two queued entries and a simultaneous dispatch
        bus.cdb_grant = 1'b0;
        drive(OP_ADD, 32'd6, 32'd0, 32'd0, 32'h0, 4'd6);
        cyc();
        drive(OP_ADD, 32'd7, 32'd0, 32'd0, 32'h0, 4'd7);
        cyc();
        bus.ALU_enable = 1'b0;
        cyc();
        chk("rb pre valid", {31'd0, bus.B_ALU_valid}, 32'd1);
        chk("rb pre tag", {28'd0, bus.B_ALU_rdTag}, 32'd6);
        rollback = 1'b1;
        drive(OP_ADD, 32'd9, 32'd0, 32'd0, 32'h0, 4'd9);
        cyc();
        rollback = 1'b0;
        bus.ALU_enable = 1'b0;
        chk("rb valid", {31'd0, bus.B_ALU_valid}, 32'd0);
        chk("rb stall", {31'd0, bus.alu_stall}, 32'd0);
        chk("rb overflow kept", {31'd0, alu_overflow}, 32'd1);
        bus.cdb_grant = 1'b1;
        saw = 1'b0;
        repeat (4) begin
            cyc();
            if (bus.B_ALU_valid) saw = 1'b1;
        end
        chk("rb no ghost", {31'd0, saw}, 32'd0);

        // rdy low freezes a valid head even with grant and dispatch present
        bus.cdb_grant = 1'b0;
        drive(OP_ADD, 32'd1, 32'd1, 32'd0, 32'h0, 4'd10);
        cyc();
        bus.ALU_enable = 1'b0;
        cyc();
        chk("rdy pre valid", {31'd0, bus.B_ALU_valid}, 32'd1);
        rdy = 1'b0;
        bus.cdb_grant = 1'b1;
        drive(OP_ADD, 32'd20, 32'd0, 32'd0, 32'h0, 4'd11);
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk($sformatf("frz%0d valid", c), {31'd0, bus.B_ALU_valid}, 32'd1);
            chk($sformatf("frz%0d tag", c), {28'd0, bus.B_ALU_rdTag}, 32'd10);
            chk($sformatf("frz%0d result", c), bus.B_ALU_result, 32'd2);
        end
        rdy = 1'b1;
        bus.ALU_enable = 1'b0;
        saw = 1'b0;
        repeat (4) begin
            cyc();
            if (bus.B_ALU_valid) saw = 1'b1;
        end
        chk("frz no late op", {31'd0, saw}, 32'd0);

        // Asynchronous reset mid-run clears queue and sticky flag
        bus.cdb_grant = 1'b0;
        drive(OP_ADD, 32'd2, 32'd2, 32'd0, 32'h0, 4'd12);
        cyc();
        bus.ALU_enable = 1'b0;
        cyc();
        chk("mid pre valid", {31'd0, bus.B_ALU_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_zero_outputs("mid reset");
        @(negedge clk);
        rst = 1'b1;
        cyc();
        chk("post reset valid", {31'd0, bus.B_ALU_valid}, 32'd0);
        chk("post reset stall", {31'd0, bus.alu_stall}, 32'd0);
        bus.cdb_grant = 1'b1;
        run_vec(vecs[0], 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side endpoint of the reservation-station dispatch interface.
- Accepts one dispatched ALU micro-op per cycle (op, Vj, Vk, imm, rdTag, pc) and computes the integer/branch result.
- Buffers results in an in-order result queue and drives the ALU side of the CDB (B_ALU_*) under a CDB grant handshake.
- Raises a stall back to the reservation station before the queue can overflow.

Parameters:
QDEPTH, 4, result queue entries (power of 2, >=2)
QW, 2, log2(QDEPTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
rdy  in  1  global ready; low freezes all state
rollback  in  1  synchronous flush of all in-flight work
ALU_enable  in  1  dispatch valid
op_to_ALU  in  6  op code (defines.v encoding)
Vj_to_ALU  in  32  operand 1
Vk_to_ALU  in  32  operand 2
imm_to_ALU  in  32  sign-extended immediate
rdTag_to_ALU  in  `ROBRange  destination ROB tag
pc_to_ALU  in  32  instruction pc
alu_stall  out  1  tells RS to hold dispatch
cdb_grant  in  1  CDB arbiter grant for the ALU source
B_ALU_valid  out  1  result broadcast valid
B_ALU_result  out  32  rd value
B_ALU_rdTag  out  `ROBRange  tag
B_ALU_jump  out  1  control transfer taken
B_ALU_target  out  32  redirect pc
alu_overflow  out  1  sticky: dispatch dropped while full

Behaviour:
- Reset (rst=0, async): stage valid=0, queue empty (head=tail=count=0), alu_overflow=0, B_ALU_valid=0, B_ALU_* data=0, alu_stall=0.
- Stage S1 register: on an edge with rdy=1 and ALU_enable=1, latch all dispatch fields and set s1_valid. With ALU_enable=0, clear s1_valid.
- Compute (combinational from S1):
  - ADD/ADDI, SUB, AND/ANDI, OR/ORI, XOR/XORI, SLT/SLTI (signed), SLTU/SLTIU (unsigned): I-forms use imm as operand 2.
  - Shifts: amount is the low 5 bits of Vk or imm. SRA is arithmetic.
  - LUI: result=imm. AUIPC: result=pc+imm.
  - JAL: result=pc+4, jump=1, target=pc+imm.
  - JALR: result=pc+4, jump=1, target=(Vj+imm)&~1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: result=0, jump=compare outcome, target=pc+imm.
  - All other ops: jump=0, target=pc+4.
  - All arithmetic is mod 2^32.
- Enqueue: at the edge after S1 is valid, push {result, rdTag, jump, target} at tail. Total latency is 2 edges from dispatch sampling to B_ALU_valid.
- B_ALU_* are driven from the head entry. B_ALU_valid = (count!=0).
- Pop: on an edge where B_ALU_valid && cdb_grant && rdy. Push and pop in the same cycle leave count unchanged. Head and tail wrap mod QDEPTH.
- alu_stall = (count + s1_valid) >= QDEPTH-1. It is combinational, so one dispatch already in flight always has room.
- Overflow: dispatch or push arriving with count==QDEPTH and no pop that cycle: the op is dropped and alu_overflow is set. The flag clears only on reset.
- rollback (rdy=1): at the next edge s1_valid=0, queue emptied, B_ALU_valid=0. A dispatch in the same cycle as rollback is discarded. alu_overflow is unaffected.
- rdy=0: no state changes, outputs held, grant ignored.

Optional Feature:
ALU_CDB_BYPASS_EN
- Defined: when the queue is empty, s1_valid=1 and cdb_grant=1, the S1 result drives B_ALU_* combinationally in the same cycle and is not enqueued. Latency is 1 edge.
- Undefined: all results pass through the queue (2-edge latency). B_ALU_* are driven only from the queue head.

Test Plan:
1. Reset with rst=0 mid-run -> all outputs 0, count 0. After release, dispatch ADD Vj=5 Vk=7 tag=3, grant=1 -> B_ALU_valid 2 edges later with result=12, tag=3, jump=0.
2. BLT Vj=0xFFFFFFFF Vk=1 pc=0x100 imm=0x20 -> jump=1, target=0x120. Same operands with BLTU -> jump=0, target=0x120.
3. JALR Vj=0x1003 imm=4 pc=0x40 -> result=0x44, jump=1, target=0x1006.
4. Hold grant=0 and dispatch back-to-back -> alu_stall rises when count+s1_valid=3 (QDEPTH=4). Forcing a 5th op sets alu_overflow. Releasing grant drains in order with tags intact.
5. Two queued entries, rollback=1 with a simultaneous dispatch -> next cycle B_ALU_valid=0, count=0, and the dispatched op never appears.
6. rdy=0 for 3 cycles with a valid head and grant=1 -> no pop, outputs stable. With ALU_CDB_BYPASS_EN and an empty queue, a SUB 10-3 appears 1 edge after dispatch with result=7.
